// File: rtl/lcd_byte_arbiter_pkg.sv
// Shared definitions for the LCD byte arbiter: FSM states, the controller init
// sequence and the common HD44780-style command codes used by requesters.
package lcd_byte_arbiter_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    XFER,
    GAP
  } state_t;

  localparam int unsigned CNT_W = 20;

  // Init sequence: 8-bit bus/2 lines, entry mode increment, display+cursor on, clear.
  localparam logic [7:0] INIT_FUNC_SET   = 8'h38;
  localparam logic [7:0] INIT_ENTRY_MODE = 8'h06;
  localparam logic [7:0] INIT_DISPLAY_ON = 8'h0E;
  localparam logic [7:0] INIT_CLEAR      = 8'h01;

  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME_L1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
  localparam logic [7:0] LCD_CMD_LINE3   = 8'h94;
  localparam logic [7:0] LCD_CMD_LINE4   = 8'hD4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_FUNC_SET;
      2'd1:    return INIT_ENTRY_MODE;
      2'd2:    return INIT_DISPLAY_ON;
      default: return INIT_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_arbiter.sv
// Two-requester arbiter in front of an LCD byte transmitter: runs the power-up
// init sequence, then grants bytes round-robin with optional ownership lock.
module lcd_byte_arbiter
  import lcd_byte_arbiter_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       cd0,
  input  logic       cd1,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] grant,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       tx_cd,
  input  logic       tx_done,
  output logic       init_done,
  output logic       busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;
  logic             last_served;
  logic             owner;

  logic             pwr_last;
  logic             gap_last;
  logic             pick1;
  logic             own_req;
  logic             own_lock;
  logic [7:0]       own_data;
  logic             own_cd;

  // A zero-length gap still spends one cycle in GAP, hence the "+1 >=" form.
  assign pwr_last = (32'(cnt) + 32'd1) >= POWERUP_CYCLES;
  assign gap_last = (32'(cnt) + 32'd1) >= GAP_CYCLES;
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    pick1    = req1 & (~req0 | ~last_served);
    own_req  = req0;
    own_lock = lock0;
    own_data = data0;
    own_cd   = cd0;
    if (owner) begin
      own_req  = req1;
      own_lock = lock1;
      own_data = data1;
      own_cd   = cd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state       <= PWRUP;
      cnt         <= '0;
      init_idx    <= '0;
      last_served <= 1'b1;
      owner       <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      tx_cd       <= 1'b0;
      grant       <= 2'b00;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        PWRUP: begin
          if (pwr_last) begin
            cnt      <= '0;
            tx_data  <= init_cmd(2'd0);
            tx_cd    <= 1'b0;
            tx_start <= 1'b1;
            state    <= INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        INIT: begin
          if (tx_done) begin
            tx_start <= 1'b0;
            cnt      <= '0;
            state    <= GAP;
          end
        end

        IDLE: begin
          if (req0 | req1) begin
            owner       <= pick1;
            last_served <= pick1;
            grant       <= pick1 ? 2'b10 : 2'b01;
            tx_data     <= pick1 ? data1 : data0;
            tx_cd       <= pick1 ? cd1 : cd0;
            tx_start    <= 1'b1;
            state       <= XFER;
          end
        end

        XFER: begin
          if (tx_done) begin
            tx_start <= 1'b0;
            ack0     <= ~owner;
            ack1     <= owner;
            cnt      <= '0;
            state    <= GAP;
          end
        end

        GAP: begin
          if (gap_last) begin
            cnt <= '0;
            if (!init_done) begin
              if (init_idx == 2'd3) begin
                init_done <= 1'b1;
                state     <= IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                tx_data  <= init_cmd(init_idx + 2'd1);
                tx_start <= 1'b1;
                state    <= INIT;
              end
            end else if (own_lock && own_req) begin
              // Locked owner keeps the transmitter without re-arbitration.
              tx_data  <= own_data;
              tx_cd    <= own_cd;
              tx_start <= 1'b1;
              state    <= XFER;
            end else begin
              grant <= 2'b00;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_byte_arbiter.sv
// Directed bench for lcd_byte_arbiter: init sequence, single request,
// contention, lock ownership and reset during a transfer.
module tb_lcd_byte_arbiter;

  localparam int unsigned PWR = 50;
  localparam int unsigned GAPC = 3;
  localparam int LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, lock0, lock1, cd0, cd1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic [1:0] grant;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_cd;
  logic       tx_done;
  logic       init_done;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_cmd [4] = '{8'h38, 8'h06, 8'h0E, 8'h01};

  always #5 clk = ~clk;

  lcd_byte_arbiter #(
    .POWERUP_CYCLES(PWR),
    .GAP_CYCLES    (GAPC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .lock0    (lock0),
    .lock1    (lock1),
    .data0    (data0),
    .data1    (data1),
    .cd0      (cd0),
    .cd1      (cd1),
    .ack0     (ack0),
    .ack1     (ack1),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_cd    (tx_cd),
    .tx_done  (tx_done),
    .init_done(init_done),
    .busy     (busy)
  );

  // Transmitter model: one-cycle tx_done pulse 5 cycles after tx_start rises.
  initial begin
    int  dcnt;
    logic prev;
    dcnt    = 0;
    prev    = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst === 1'b1) begin
        dcnt = 0;
      end else begin
        if (dcnt != 0) begin
          dcnt--;
          if (dcnt == 0) tx_done = 1'b1;
        end
        if (tx_start === 1'b1 && prev !== 1'b1) dcnt = 5;
      end
      prev = tx_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Assumes reset was released at the current negedge; checks the whole init run.
  task automatic run_init(input string tag);
    int n;
    bit acked;
    acked = 1'b0;
    for (int i = 0; i < int'(PWR) - 1; i++) begin
      @(negedge clk);
      if (ack0 | ack1) acked = 1'b1;
    end
    vectors++;
    if (tx_start !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pwrup_hold: tx_start=%b busy=%b init_done=%b, expected 0 1 0",
               tag, tx_start, busy, init_done);
    end
    @(negedge clk);
    vectors++;
    if (tx_start !== 1'b1) begin
      miscompares++;
      $display("FAIL %s pwrup_end: tx_start=%b, expected 1", tag, tx_start);
    end
    for (int c = 0; c < 4; c++) begin
      n = 0;
      while (tx_start !== 1'b1 && n < LIMIT) begin
        @(negedge clk);
        n++;
        if (ack0 | ack1) acked = 1'b1;
      end
      vectors++;
      if (n >= LIMIT || tx_data !== exp_cmd[c] || tx_cd !== 1'b0 || grant !== 2'b00) begin
        miscompares++;
        $display("FAIL %s init_cmd%0d: data=%h cd=%b grant=%b, expected data=%h cd=0 grant=00",
                 tag, c, tx_data, tx_cd, grant, exp_cmd[c]);
      end
      n = 0;
      while (tx_start !== 1'b0 && n < LIMIT) begin
        @(negedge clk);
        n++;
        if (ack0 | ack1) acked = 1'b1;
      end
      vectors++;
      if (n != 6) begin
        miscompares++;
        $display("FAIL %s init_start_width%0d: %0d cycles, expected 6", tag, c, n);
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (ack0 | ack1) acked = 1'b1;
    end
    vectors++;
    if (init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s init_done_early: init_done=%b, expected 0", tag, init_done);
    end
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s init_done_rise: init_done=%b busy=%b, expected 1 0", tag, init_done, busy);
    end
    vectors++;
    if (acked) begin
      miscompares++;
      $display("FAIL %s init_ack: ack seen during init, expected none", tag);
    end
  endtask

  // Follows one byte from latch to ack; optionally drops requests mid-transfer.
  task automatic observe_byte(input logic [1:0] eg, input logic [7:0] ed, input logic ec,
                              input bit drop, input string tag);
    int n;
    bit stable;
    n = 0;
    while (tx_start !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= LIMIT || grant !== eg || tx_data !== ed || tx_cd !== ec) begin
      miscompares++;
      $display("FAIL %s latch: grant=%b data=%h cd=%b, expected grant=%b data=%h cd=%b",
               tag, grant, tx_data, tx_cd, eg, ed, ec);
    end
    if (drop) begin
      req0  = 1'b0;
      req1  = 1'b0;
      data0 = ~data0;
      data1 = ~data1;
    end
    stable = 1'b1;
    n = 0;
    while (tx_start !== 1'b0 && n < LIMIT) begin
      if (grant !== eg || tx_data !== ed || busy !== 1'b1 || (ack0 | ack1)) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!stable || n != 6) begin
      miscompares++;
      $display("FAIL %s xfer: stable=%b width=%0d, expected stable=1 width=6", tag, stable, n);
    end
    vectors++;
    if ({ack1, ack0} !== eg) begin
      miscompares++;
      $display("FAIL %s ack: ack1ack0=%b, expected %b", tag, {ack1, ack0}, eg);
    end
    @(negedge clk);
    vectors++;
    if ({ack1, ack0} !== 2'b00 || grant !== eg) begin
      miscompares++;
      $display("FAIL %s ack_pulse: ack1ack0=%b grant=%b, expected 00 and grant %b",
               tag, {ack1, ack0}, grant, eg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || tx_cd !== 1'b0 || grant !== 2'b00 ||
        ack0 !== 1'b0 || ack1 !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: start=%b data=%h cd=%b grant=%b ack=%b%b init=%b busy=%b, expected 0 00 0 00 00 0 1",
               tx_start, tx_data, tx_cd, grant, ack1, ack0, init_done, busy);
    end
  endtask

  task automatic test_powerup();
    req0 = 1'b1;  // requests must be ignored until init completes
    data0 = 8'hEE;
    rst = 1'b0;
    run_init("powerup");
    req0 = 1'b0;
  endtask

  task automatic test_contention();
    data0 = 8'h30; cd0 = 1'b1;
    data1 = 8'h31; cd1 = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    observe_byte(2'b01, 8'h30, 1'b1, 1'b0, "contend0");
    observe_byte(2'b10, 8'h31, 1'b0, 1'b0, "contend1");
    observe_byte(2'b01, 8'h30, 1'b1, 1'b0, "contend2");
    observe_byte(2'b10, 8'h31, 1'b0, 1'b0, "contend3");
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    data0 = 8'h41;
    cd0   = 1'b1;
    req0  = 1'b1;
    observe_byte(2'b01, 8'h41, 1'b1, 1'b1, "single");
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || grant !== 2'b01) begin
      miscompares++;
      $display("FAIL single_gap: busy=%b grant=%b, expected 1 01", busy, grant);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || grant !== 2'b00 || tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: busy=%b grant=%b start=%b, expected 0 00 0", busy, grant, tx_start);
    end
  endtask

  task automatic test_lock();
    data0 = 8'h55; cd0 = 1'b1; req0 = 1'b1;
    data1 = 8'h48; cd1 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
    observe_byte(2'b10, 8'h48, 1'b1, 1'b0, "lock_b0");
    data1 = 8'h49;
    observe_byte(2'b10, 8'h49, 1'b1, 1'b0, "lock_b1");
    data1 = 8'h4A;
    observe_byte(2'b10, 8'h4A, 1'b1, 1'b0, "lock_b2");
    lock1 = 1'b0;
    req1  = 1'b0;
    observe_byte(2'b01, 8'h55, 1'b1, 1'b1, "lock_after");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    data1 = 8'h77; cd1 = 1'b1; req1 = 1'b1;
    n = 0;
    while (tx_start !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= LIMIT || grant !== 2'b10 || tx_data !== 8'h77) begin
      miscompares++;
      $display("FAIL rst_xfer_start: grant=%b data=%h, expected 10 77", grant, tx_data);
    end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_start !== 1'b0 || grant !== 2'b00 || ack0 !== 1'b0 || ack1 !== 1'b0 ||
        init_done !== 1'b0 || busy !== 1'b1 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_xfer_abort: start=%b grant=%b ack=%b%b init=%b busy=%b data=%h, expected 0 00 00 0 1 00",
               tx_start, grant, ack1, ack0, init_done, busy, tx_data);
    end
    rst = 1'b0;
    run_init("reinit");
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00; cd0 = 1'b0; cd1 = 1'b0;
    test_reset();
    test_powerup();
    test_contention();
    test_single();
    test_lock();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
